// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: operands stream in LSD first,
// one result digit per accepted input digit, one cycle later.
module digit_serial_addsub #(
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic               sub,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               last,
    output logic               out_vld,
    output logic [DIGIT_W-1:0] sum,
    output logic               out_last,
    output logic               cout,
    output logic               ovf,
    output logic               len_err,
    output logic               dbg_state
);

    localparam int CNT_W = $clog2(MAX_DIGITS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIGITS - 1);

    // Handshake: a digit is consumed on every rising edge where vld=1; there is
    // no backpressure. Each consumed digit yields exactly one out_vld cycle.
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t             r_state;
    logic               r_mode;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_vld;
    logic [DIGIT_W-1:0] r_sum;
    logic               r_out_last;
    logic               r_cout;
    logic               r_ovf;
    logic               r_len_err;

    logic               w_first;
    logic               w_mode;
    logic               w_cin;
    logic [DIGIT_W-1:0] w_bx;
    logic [DIGIT_W:0]   w_full;
    logic [DIGIT_W-1:0] w_s;
    logic               w_c;
    logic               w_c_msb;
    logic               w_ovf;
    logic               w_term;

    assign w_first = (r_state == S_IDLE);
    assign w_mode  = w_first ? sub : r_mode;
    assign w_cin   = w_first ? sub : r_carry;
    assign w_bx    = w_mode ? ~b : b;
    assign w_full  = {1'b0, a} + {1'b0, w_bx} + {{DIGIT_W{1'b0}}, w_cin};
    assign w_s     = w_full[DIGIT_W-1:0];
    assign w_c     = w_full[DIGIT_W];
    // Carry into the top bit recovered from the sum bit, so DIGIT_W=1 also works.
    assign w_c_msb = w_s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ w_bx[DIGIT_W-1];
    assign w_ovf   = w_c_msb ^ w_c;
    assign w_term  = last | (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_out_vld  <= 1'b0;
            r_sum      <= '0;
            r_out_last <= 1'b0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_len_err  <= 1'b0;
        end else if (vld) begin
            r_out_vld <= 1'b1;
            r_sum     <= w_s;
            r_mode    <= w_mode;
            if (w_term) begin
                r_state    <= S_IDLE;
                r_carry    <= 1'b0;
                r_cnt      <= '0;
                r_out_last <= 1'b1;
                r_cout     <= w_c;
                r_ovf      <= w_ovf;
                r_len_err  <= ~last;
            end else begin
                r_state    <= S_BUSY;
                r_carry    <= w_c;
                r_cnt      <= r_cnt + CNT_W'(1);
                r_out_last <= 1'b0;
                r_cout     <= 1'b0;
                r_ovf      <= 1'b0;
                r_len_err  <= 1'b0;
            end
        end else begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
        end
    end

    assign out_vld   = r_out_vld;
    assign sum       = r_sum;
    assign out_last  = r_out_last;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign len_err   = r_len_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub: whole-operand integer reference model,
// directed scenarios followed by randomized streams with gaps and stray last pulses.
module tb_digit_serial_addsub;

    localparam int W = 4;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         vld;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         last;
    logic         out_vld;
    logic [W-1:0] sum;
    logic         out_last;
    logic         cout;
    logic         ovf;
    logic         len_err;
    logic         dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [6:0] prev_out = '0;

    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    int          op_n = 0;
    logic        op_mode = 1'b0;

    digit_serial_addsub #(.DIGIT_W(W), .MAX_DIGITS(M)) dut (
        .clk(clk), .rst(rst), .vld(vld), .sub(sub), .a(a), .b(b), .last(last),
        .out_vld(out_vld), .sum(sum), .out_last(out_last), .cout(cout),
        .ovf(ovf), .len_err(len_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accumulate the operands as integers and derive each
    // result digit, carry and signed overflow from whole-number arithmetic.
    task automatic model_push(input logic [W-1:0] da, input logic [W-1:0] db,
                              input logic ds, input logic dl);
        logic [63:0] full, mask, bx, tot;
        longint      sa, sb, r, half;
        logic        term, co, ov, le;
        logic [W-1:0] sd;
        if (op_n == 0) op_mode = ds;
        op_a = op_a | (64'(da) << (W * op_n));
        op_b = op_b | (64'(db) << (W * op_n));
        op_n++;
        full = 64'd1 << (W * op_n);
        mask = full - 64'd1;
        bx   = op_mode ? (~op_b & mask) : op_b;
        tot  = op_a + bx + 64'(op_mode);
        sd   = W'((tot >> (W * (op_n - 1))) & 64'hF);
        term = dl || (op_n == M);
        co = 1'b0; ov = 1'b0; le = 1'b0;
        if (term) begin
            co   = tot[W * op_n];
            half = longint'(full >> 1);
            sa   = (op_a >= (full >> 1)) ? longint'(op_a) - longint'(full) : longint'(op_a);
            sb   = (op_b >= (full >> 1)) ? longint'(op_b) - longint'(full) : longint'(op_b);
            r    = op_mode ? sa - sb : sa + sb;
            ov   = (r < -half) || (r >= half);
            le   = !dl;
            op_a = '0; op_b = '0; op_n = 0;
        end
        exp_q.push_back({le, ov, co, term, sd});
    endtask

    task automatic drive_digit(input logic [W-1:0] da, input logic [W-1:0] db,
                               input logic ds, input logic dl);
        @(posedge clk);
        #1;
        vld = 1'b1; a = da; b = db; sub = ds; last = dl;
        model_push(da, db, ds, dl);
    endtask

    // Idle cycles with junk on the data pins and random last while vld=0.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            vld  = 1'b0;
            last = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            a    = W'($urandom_range(0, 15));
            b    = W'($urandom_range(0, 15));
        end
    endtask

    // monitor
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            prev_out = '0;
        end else if (out_vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_vld", 32'(out_vld), 32'(1'b0));
            end else begin
                e = exp_q.pop_front();
                chk("digit", {24'd0, len_err, ovf, cout, out_last, sum}, {24'd0, e});
            end
            prev_out = {len_err, ovf, cout, sum};
        end else begin
            chk("idle_hold", {25'd0, out_last, len_err, ovf, cout, sum}, {25'd0, 1'b0, prev_out});
        end
    end

    initial begin
        int len;
        rst = 1'b1; vld = 1'b0; sub = 1'b0; a = '0; b = '0; last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, out_vld, out_last, cout, ovf, len_err, dbg_state}, 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        rst = 1'b0;

        // 0x3C + 0x29
        drive_digit(4'hC, 4'h9, 1'b0, 1'b0);
        drive_digit(4'h3, 4'h2, 1'b0, 1'b1);
        idle(2);
        // 0x50 - 0x70
        drive_digit(4'h0, 4'h0, 1'b1, 1'b0);
        drive_digit(4'h5, 4'h7, 1'b1, 1'b1);
        // 0x7F + 0x01, back-to-back then with 3-cycle gaps
        drive_digit(4'hF, 4'h1, 1'b0, 1'b0);
        drive_digit(4'h7, 4'h0, 1'b0, 1'b1);
        idle(3);
        drive_digit(4'hF, 4'h1, 1'b0, 1'b0);
        idle(3);
        drive_digit(4'h7, 4'h0, 1'b0, 1'b1);
        idle(2);
        // length limit: five F+1 digits without last, then close the new op
        repeat (5) drive_digit(4'hF, 4'h1, 1'b0, 1'b0);
        drive_digit(4'h0, 4'h0, 1'b0, 1'b1);
        // sub flipped mid-operation must be ignored
        drive_digit(4'h4, 4'h6, 1'b1, 1'b0);
        drive_digit(4'h2, 4'h1, 1'b0, 1'b0);
        drive_digit(4'h9, 4'h3, 1'b0, 1'b1);
        idle(2);

        // reset between digits of 0xFF + 0x01
        drive_digit(4'hF, 4'h1, 1'b0, 1'b0);
        idle(1);
        @(posedge clk);
        #1;
        chk("busy_before_reset", 32'(dbg_state), 32'd1);
        #1;
        rst = 1'b1;
        op_a = '0; op_b = '0; op_n = 0;
        #1;
        chk("async_reset_outputs", {26'd0, out_vld, out_last, cout, ovf, len_err, dbg_state}, 32'd0);
        chk("async_reset_sum", 32'(sum), 32'd0);
        vld = 1'b1; last = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_ignores_inputs", 32'(out_vld), 32'd0);
        vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_digit(4'h1, 4'h1, 1'b0, 1'b1);
        idle(2);

        // randomized streams
        for (int op = 0; op < 80; op++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                drive_digit(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                            1'($urandom_range(0, 1)), k == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(1);

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

Interface
REQ-001 Parameter DIGIT_W, default 4, meaning bits per digit (>=1).
REQ-002 Parameter MAX_DIGITS, default 16, meaning max digits per operand (>=1).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 vld  input  1  current input digit valid.
REQ-006 sub  input  1  mode, 0=add a+b, 1=subtract a-b; sampled on first digit of an operation only.
REQ-007 a  input  DIGIT_W  operand A digit, least-significant digit first.
REQ-008 b  input  DIGIT_W  operand B digit, least-significant digit first.
REQ-009 last  input  1  current digit is the most-significant digit; qualified by vld.
REQ-010 out_vld  output  1  result digit valid.
REQ-011 sum  output  DIGIT_W  result digit.
REQ-012 out_last  output  1  result digit is final digit of operation.
REQ-013 cout  output  1  raw carry out of final digit; valid with out_last (sub: 0 means borrow).
REQ-014 ovf  output  1  two's-complement signed overflow of the whole operation; valid with out_last.
REQ-015 len_err  output  1  operation forcibly terminated at MAX_DIGITS; valid with out_last.

Function
REQ-016 State: IDLE (no operation open) and BUSY (at least one digit consumed, last not yet seen).
REQ-017 IDLE, vld=1: latch sub into mode register; carry-in = sub; go BUSY unless digit terminates operation.
REQ-018 BUSY, vld=1: mode register used, sub ignored; carry-in = stored carry.
REQ-019 Digit arithmetic: {c, s} = a + (mode ? ~b : b) + carry-in, computed at DIGIT_W+1 bits.
REQ-020 All outputs registered; latency exactly 1 cycle: digit accepted at edge N appears on outputs after edge N, held until edge N+1.
REQ-021 out_vld = registered vld; out_last = registered (vld & terminate); sum = registered s.
REQ-022 vld=0: carry, mode, digit counter, state held; out_vld=0, out_last=0; sum, cout, ovf, len_err hold previous values.
REQ-023 last with vld=0 ignored.
REQ-024 Terminate = last | (digit counter == MAX_DIGITS-1); on terminating digit: state->IDLE, carry and counter cleared.
REQ-025 Digit counter counts accepted digits of current operation, width clog2(MAX_DIGITS)+1, never wraps.
REQ-026 cout = c of terminating digit; ovf = carry into bit DIGIT_W-1 XOR carry out of bit DIGIT_W-1 of terminating digit.
REQ-027 len_err = 1 with out_last when terminate caused by counter while last=0; 0 otherwise (last on MAX_DIGITS-th digit is not an error).
REQ-028 Single-digit operation (vld&last in IDLE) valid: carry-in = sub, terminates same cycle.
REQ-029 Non-terminating digits: cout, ovf, len_err driven 0 with out_vld.
REQ-030 Back-to-back operations: digit following terminating digit starts new operation with no idle cycle.

Reset
REQ-031 rst=1 asynchronously forces IDLE, carry=0, mode=0, counter=0, out_vld=0, sum=0, out_last=0, cout=0, ovf=0, len_err=0.
REQ-032 Reset mid-operation discards partial operation; first vld digit after release starts new operation.
REQ-033 Inputs ignored while rst=1.

Verification (DIGIT_W=4, MAX_DIGITS=4)
REQ-034 Add 0x3C+0x29: digits (C,9),(3,2 last) sub=0 -> sum 5 then 6, out_last on 2nd, cout=0, ovf=0.
REQ-035 Sub 0x50-0x70: digits (0,0),(5,7 last) sub=1 -> sum 0 then E, cout=0 (borrow), ovf=0.
REQ-036 Add 0x7F+0x01 -> sum F+1: 0, then 8; ovf=1, cout=0; repeat with vld=0 gaps of 3 cycles between digits -> identical outputs, out_vld only for valid digits.
REQ-037 Five digits all F+1 with no last -> 4th output has out_last=1, len_err=1; 5th digit starts new op: sum 0, out_last=0 (carry-in 0 for add).
REQ-038 Assert rst between digits of 0xFF+0x01 (after first digit) -> all outputs 0 immediately; next op 0x1+0x1 single digit -> sum 2, out_last=1, cout=0.
REQ-039 Sub toggled mid-operation (digits 2..n sub flipped) -> result unchanged vs. constant sub; last with vld=0 -> no out_vld, no state change.
